// File: rtl/regfile_pkg.sv
// Shared register-file constants, requester indices and the write-request record.
package regfile_pkg;

    localparam int REG_DW  = 16;
    localparam int REG_AW  = 4;
    localparam int REG_NUM = 2 ** REG_AW;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IO   = 2;

    typedef struct packed {
        logic [REG_AW-1:0] sel;
        logic [REG_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with per-requester priority lock; reusable
// for any shared port (register-file write port, memory port).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [N-1:0]  lock,
    input  logic          hold,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    localparam int unsigned NU = N;

    int unsigned idx;
    logic        found;

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NU) begin
                idx = idx - NU;
            end
            if (!found && !hold && valid[idx[PW-1:0]]) begin
                found               = 1'b1;
                grant[idx[PW-1:0]]  = 1'b1;
                if (lock[idx[PW-1:0]]) begin
                    next_ptr = idx[PW-1:0];
                end else if (idx == NU - 1) begin
                    next_ptr = '0;
                end else begin
                    next_ptr = PW'(idx + 1);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin sharing of the register-file write port with a registered write
// stage and a busy bitmap. REGFILE_R0_ZERO_EN makes R0 a hardwired zero register.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = REG_DW,
    parameter int AW   = REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_sel,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 hold,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_sel,
    output logic [DW-1:0]        wr_data,
    output logic [2**AW-1:0]     busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2 ** AW;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic            g_write;
    logic [AW-1:0]   g_sel;
    logic [DW-1:0]   g_data;

    // Reset also blocks grants so ready stays low while rst is high.
    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .valid    (req_valid),
        .lock     (req_lock),
        .hold     (hold | rst),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        g_sel  = '0;
        g_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_sel  = req_sel[i*AW +: AW];
                g_data = req_data[i*DW +: DW];
            end
        end
    end

`ifdef REGFILE_R0_ZERO_EN
    assign g_write = any_grant && (g_sel != '0);
`else
    assign g_write = any_grant;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= g_write;
            if (any_grant) begin
                rr_ptr  <= next_ptr;
                wr_sel  <= g_sel;
                wr_data <= g_data;
            end
        end
    end

    always_comb begin
        busy = '0;
        if (wr_en) begin
            busy[wr_sel] = 1'b1;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                busy[req_sel[i*AW +: AW]] = 1'b1;
            end
        end
`ifdef REGFILE_R0_ZERO_EN
        busy[0] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vector table, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = REG_DW;
    localparam int AW   = REG_AW;
    localparam int NREG = REG_NUM;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ*AW-1:0]  req_sel;
    logic [NREQ*DW-1:0]  req_data;
    logic                hold;
    logic                wr_en;
    logic [AW-1:0]       wr_sel;
    logic [DW-1:0]       wr_data;
    logic [NREG-1:0]     busy;

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lock  (req_lock),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: pointer plus the write the register file sees next.
    int            m_ptr = 0;
    logic          m_we  = 1'b0;
    logic [AW-1:0] m_ws  = '0;
    logic [DW-1:0] m_wd  = '0;

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  l;
        logic        h;
        logic [11:0] s;
        logic [47:0] d;
        logic [2:0]  rdy;
        logic        we;
        logic [3:0]  ws;
        logic [15:0] wd;
        logic        b7;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l, input logic h,
                                input logic [11:0] s, input logic [47:0] d,
                                input logic [2:0] rdy, input logic we, input logic [3:0] ws,
                                input logic [15:0] wd, input logic b7);
        vec_t r;
        r.v = v; r.l = l; r.h = h; r.s = s; r.d = d;
        r.rdy = rdy; r.we = we; r.ws = ws; r.wd = wd; r.b7 = b7;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int winner();
        if (rst || hold) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Compare every output against the model, advance the model across the
    // next rising edge, and return at 1 time unit after that edge.
    task automatic model_step();
        int              w;
        logic [NREG-1:0] eb;
        logic [AW-1:0]   s;
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_ws = '0; m_wd = '0;
        end
        w = winner();
        eb = '0;
        if (m_we) eb[m_ws] = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i]) eb[req_sel[i*AW +: AW]] = 1'b1;
`ifdef REGFILE_R0_ZERO_EN
        eb[0] = 1'b0;
`endif
        check("model req_ready", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
        check("model wr_en",     32'(wr_en),     32'(m_we));
        check("model wr_sel",    32'(wr_sel),    32'(m_ws));
        check("model wr_data",   32'(wr_data),   32'(m_wd));
        check("model busy",      32'(busy),      32'(eb));
        if (!rst) begin
            if (w >= 0) begin
                s = req_sel[w*AW +: AW];
`ifdef REGFILE_R0_ZERO_EN
                m_we = (s != '0);
`else
                m_we = 1'b1;
`endif
                m_ws  = s;
                m_wd  = req_data[w*DW +: DW];
                m_ptr = req_lock[w] ? w : (w + 1) % NREQ;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic h,
                         input logic [11:0] s, input logic [47:0] d);
        req_valid = v; req_lock = l; hold = h; req_sel = s; req_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d0;
        d0 = 48'hC333_B222_A111;

        tbl[0]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b001, 1'b0, 4'h0, 16'h0000, 1'b0);
        tbl[1]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b010, 1'b1, 4'h1, 16'hA111, 1'b0);
        tbl[2]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b100, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[3]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b001, 1'b1, 4'h3, 16'hC333, 1'b0);
        tbl[4]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b010, 1'b1, 4'h1, 16'hA111, 1'b0);
        tbl[5]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b100, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[6]  = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b001, 1'b1, 4'h3, 16'hC333, 1'b0);
        tbl[7]  = mk(3'b111, 3'b010, 1'b0, 12'h321, d0, 3'b010, 1'b1, 4'h1, 16'hA111, 1'b0);
        tbl[8]  = mk(3'b111, 3'b010, 1'b0, 12'h321, d0, 3'b010, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[9]  = mk(3'b111, 3'b010, 1'b0, 12'h321, d0, 3'b010, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[10] = mk(3'b101, 3'b000, 1'b0, 12'h321, d0, 3'b100, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[11] = mk(3'b101, 3'b000, 1'b0, 12'h323, 48'hC333_B222_BEEF, 3'b001, 1'b1, 4'h3, 16'hC333, 1'b0);
        tbl[12] = mk(3'b111, 3'b000, 1'b1, 12'h321, d0, 3'b000, 1'b1, 4'h3, 16'hBEEF, 1'b0);
        tbl[13] = mk(3'b111, 3'b000, 1'b1, 12'h321, d0, 3'b000, 1'b0, 4'h3, 16'hBEEF, 1'b0);
        tbl[14] = mk(3'b111, 3'b000, 1'b1, 12'h321, d0, 3'b000, 1'b0, 4'h3, 16'hBEEF, 1'b0);
        tbl[15] = mk(3'b111, 3'b000, 1'b0, 12'h321, d0, 3'b010, 1'b0, 4'h3, 16'hBEEF, 1'b0);
        tbl[16] = mk(3'b100, 3'b000, 1'b0, 12'h321, d0, 3'b100, 1'b1, 4'h2, 16'hB222, 1'b0);
        tbl[17] = mk(3'b101, 3'b000, 1'b0, 12'h727, 48'h2222_B222_1111, 3'b001, 1'b1, 4'h3, 16'hC333, 1'b1);
        tbl[18] = mk(3'b100, 3'b000, 1'b0, 12'h727, 48'h2222_B222_1111, 3'b100, 1'b1, 4'h7, 16'h1111, 1'b1);
        tbl[19] = mk(3'b000, 3'b000, 1'b0, 12'h727, 48'h2222_B222_1111, 3'b000, 1'b1, 4'h7, 16'h2222, 1'b1);
        tbl[20] = mk(3'b000, 3'b000, 1'b0, 12'h727, 48'h2222_B222_1111, 3'b000, 1'b0, 4'h7, 16'h2222, 1'b0);

        rst = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 12'h321, d0);
        repeat (2) @(posedge clk);
        #3;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset wr_en",     32'(wr_en),     32'd0);
        check("reset wr_sel",    32'(wr_sel),    32'd0);
        check("reset wr_data",   32'(wr_data),   32'd0);
        model_step();
        rst = 1'b0;

        // Fairness, lock burst, hold and same-register collision.
        for (int n = 0; n < 21; n++) begin
            drive(tbl[n].v, tbl[n].l, tbl[n].h, tbl[n].s, tbl[n].d);
            #2;
            check($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(tbl[n].rdy));
            check($sformatf("row%0d wr_en", n),     32'(wr_en),     32'(tbl[n].we));
            check($sformatf("row%0d wr_sel", n),    32'(wr_sel),    32'(tbl[n].ws));
            check($sformatf("row%0d wr_data", n),   32'(wr_data),   32'(tbl[n].wd));
            check($sformatf("row%0d busy7", n),     32'(busy[7]),   32'(tbl[n].b7));
            model_step();
        end

        // Write to R0 from the load unit.
        drive(3'b010, 3'b000, 1'b0, 12'h000, 48'h0000_FFFF_0000);
        #2;
        check("r0 req_ready", 32'(req_ready), 32'(1 << REQ_LOAD));
`ifdef REGFILE_R0_ZERO_EN
        check("r0 busy0", 32'(busy[0]), 32'd0);
`else
        check("r0 busy0", 32'(busy[0]), 32'd1);
`endif
        model_step();
        drive(3'b000, 3'b000, 1'b0, 12'h000, 48'h0);
        #2;
`ifdef REGFILE_R0_ZERO_EN
        check("r0 wr_en", 32'(wr_en), 32'd0);
`else
        check("r0 wr_en",   32'(wr_en),   32'd1);
        check("r0 wr_sel",  32'(wr_sel),  32'd0);
        check("r0 wr_data", 32'(wr_data), 32'hFFFF);
`endif
        model_step();

        // Reset arriving while a write to R5 is on the port.
        drive(3'b001, 3'b000, 1'b0, 12'h005, 48'h0000_0000_1234);
        #2;
        check("rstmid grant", 32'(req_ready), 32'(1 << REQ_ALU));
        model_step();
        drive(3'b000, 3'b000, 1'b0, 12'h005, 48'h0000_0000_1234);
        #2;
        check("rstmid wr_en before",  32'(wr_en),  32'd1);
        check("rstmid wr_sel before", 32'(wr_sel), 32'd5);
        rst = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 12'h321, d0);
        #1;
        check("rstmid wr_en",     32'(wr_en),     32'd0);
        check("rstmid wr_sel",    32'(wr_sel),    32'd0);
        check("rstmid wr_data",   32'(wr_data),   32'd0);
        check("rstmid req_ready", 32'(req_ready), 32'd0);
        model_step();
        rst = 1'b0;
        #2;
        check("after reset first grant", 32'(req_ready), 32'(1 << REQ_ALU));
        model_step();

        // Randomized traffic; narrow sel range forces collisions and R0 writes.
        for (int n = 0; n < 400; n++) begin
            logic [11:0] s;
            logic [47:0] d;
            for (int i = 0; i < NREQ; i++) s[i*AW +: AW] = AW'($urandom_range(0, 7));
            d = {16'($urandom), 16'($urandom), 16'($urandom)};
            drive(3'($urandom), 3'($urandom & $urandom), ($urandom_range(0, 7) == 0), s, d);
            #2;
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback sources: ALU writeback, load unit, IO/interrupt context restore.
- Round-robin arbitration with valid/ready handshakes on the requester side.
- Registered write stage drives the register file's Rd/RdSEL/WRT.
- Publishes a busy bitmap for hazard/stall logic in the decoder.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- DW, 16, data width; matches register file word.
- AW, 4, register select width; 2**AW registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request i has a write pending.
- req_ready  out  NREQ  grant to request i; transfer when valid&ready.
- req_lock  in  NREQ  requester i keeps priority for the following cycle (burst restore).
- req_sel  in  NREQ*AW  packed destination register; slice i = [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; slice i = [i*DW +: DW].
- hold  in  1  freeze: no grants while high.
- wr_en  out  1  to register file WRT.
- wr_sel  out  AW  to register file RdSEL.
- wr_data  out  DW  to register file Rd.
- busy  out  2**AW  bit r set while a write to register r is requested or in flight.

Behaviour:
- Reset (async, rst=1): wr_en=0, wr_sel=0, wr_data=0, rr_ptr=0, lock_owner invalid. req_ready=0 while rst high. An in-flight write is dropped. busy reflects only live req_valid inputs.
- Arbitration (combinational, same cycle):
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - At most one req_ready bit high. req_ready[w]=1 only if req_valid[w]=1 and hold=0.
  - Requesters hold valid/sel/data stable until ready. Ready never depends on it being asserted in a prior cycle.
- Pointer update on a grant to w:
  - If req_lock[w]=1, rr_ptr<=w, so w wins next cycle if still valid.
  - Otherwise rr_ptr<=(w+1) mod NREQ.
  - No grant: rr_ptr unchanged.
- Output stage, latency 1:
  - On a grant, next edge: wr_en<=1, wr_sel<=req_sel[w], wr_data<=req_data[w].
  - No grant: wr_en<=0; wr_sel/wr_data hold their last values.
  - Back-to-back grants give one write per cycle; throughput 1.
- busy[r] = (wr_en & wr_sel==r) | OR over i of (req_valid[i] & req_sel[i]==r). Purely combinational.
- hold: takes effect the same cycle (ready=0). A write already registered still completes on the next edge. wr_en=0 from the cycle after hold rises.
- Same sel from two requesters: each is granted in turn. Register file order follows grant order; the last granted value persists.
- Valid dropped without ready: allowed (request withdrawn). Pointer unaffected.
- NREQ not a power of two: pointer wraps NREQ-1 -> 0 explicitly.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Writes with sel==0 are handshaken normally (ready/pointer as usual), but wr_en stays 0 for that cycle.
  - busy[0] is forced to 0. R0 is a hardwired zero register.
- Undefined: register 0 is written like any other.

Decomposition:
- Shared package regfile_pkg:
  - REG_DW=16, REG_AW=4, REG_NUM=16.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_IO=2.
  - typedef wr_req_t {sel, data}.
- One sub-module: rr_arbiter (parameter N; inputs valid, lock, hold, ptr; outputs onehot grant, next_ptr). Reusable for the memory-port arbiter.
- Output register stage and busy logic stay in the top.

Test Plan:
- Reset mid-write: assert rst while wr_en=1 (sel=5) -> wr_en=0, wr_sel=0, wr_data=0 immediately. First grant after release goes to req 0 if all valid.
- Fairness: all three requesters valid continuously, no lock -> grant sequence 0,1,2,0,1,2. wr_en=1 every cycle. wr_sel/wr_data equal each requester's values one cycle after its grant.
- Lock burst: req1 valid with lock=1 for 3 cycles, req0/req2 valid -> req1 granted 3 consecutive cycles, then req2, then req0.
- Hold: grant to req0 (sel=3, data=0xBEEF) in cycle N, hold=1 in N+1..N+3 -> wr_en=1 in N+1 only, 0 in N+2..N+4. No req_ready during hold. Grants resume the cycle hold falls.
- Busy/collision: req0 sel=7 data=0x1111, req2 sel=7 data=0x2222 same cycle, ptr=0 -> busy[7]=1 until the second write's wr_en cycle ends. Final wr_data sequence 0x1111 then 0x2222.
- REGFILE_R0_ZERO_EN: req1 sel=0 data=0xFFFF -> req_ready[1]=1, wr_en stays 0, busy[0]=0. Without the macro: wr_en=1, wr_sel=0, wr_data=0xFFFF.
